// File: rtl/prog_run_ctrl_pkg.sv
// Shared definitions for the program load/run/dump sequencer.
//   state_e   : sequencer states
//   IM_STRIDE : byte stride between consecutive instruction-memory words
//   DM_STRIDE : byte stride between consecutive data-memory words
package prog_run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDump,
    StDone
  } state_e;

  localparam int unsigned IM_STRIDE = 4;
  localparam int unsigned DM_STRIDE = 8;

endpackage

// File: rtl/prog_run_dump_port.sv
// Data-memory dump port: walks DM word addresses and presents each word on a
// valid/ready output register, with one bubble cycle between beats so that the
// combinational DM read has a full cycle after each address change.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en_i           : high while the sequencer is dumping; low clears the walk
//   dm_addr_o      : DM byte address of the current word
//   dm_rdata_i     : combinational DM read data for dm_addr_o
//   dump_valid_o   : dump word valid
//   dump_ready_i   : consumer ready
//   dump_data_o    : registered dump word
//   dump_idx_o     : index of the current dump word
//   last_o         : final beat accepted this cycle
module prog_run_dump_port
  import prog_run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned DUMP_WORDS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] dm_addr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [LEN_W-1:0]  dump_idx_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              is_last;

  assign is_last = (idx_q == LEN_W'(DUMP_WORDS - 1));
  assign last_o  = en_i & valid_q & dump_ready_i & is_last;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (!en_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (!valid_q) begin
      // Address has been stable for this cycle; capture the word.
      valid_d = 1'b1;
      data_d  = dm_rdata_i;
    end else if (dump_ready_i) begin
      valid_d = 1'b0;
      idx_d   = is_last ? '0 : idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign dm_addr_o    = ADDR_W'(idx_q) * ADDR_W'(DM_STRIDE);
  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_idx_o   = idx_q;

endmodule

// File: rtl/prog_run_ctrl.sv
// Boot/run sequencer for the pipelined core: loads a program into IM, runs the
// core for a bounded budget (or until halt), then streams DM contents out.
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin load/run/dump (ignored while busy)
//   prog_len           : instruction count, sampled on accepted start
//   run_cycles         : run budget, sampled on accepted start (0 acts as 1)
//   in_valid/in_ready  : loader word handshake, in_instr is the word
//   imem_we/addr/wdata : IM write port
//   cpu_rst            : core reset, low only while running
//   cpu_halt           : core halt, honoured only while running
//   dm_sel/dm_addr     : DM read-port ownership and address while dumping
//   dm_rdata           : DM combinational read data
//   dump_valid/ready   : dump word handshake; dump_data/dump_idx the word
//   busy/done/err      : status; err pulses on a rejected start
module prog_run_ctrl
  import prog_run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned DUMP_WORDS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   prog_len,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  input  logic               cpu_halt,
  output logic               dm_sel,
  output logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DATA_W-1:0]  dump_data,
  output logic [LEN_W-1:0]   dump_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CYC_W-1:0]   run_q, run_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               err_q, err_d;

  logic               xfer;
  logic               run_last;
  logic               dump_en;
  logic               dump_last;
  logic [CYC_W:0]     cyc_inc;

  assign in_ready = (state_q == StLoad) && (word_cnt_q < len_q);
  assign xfer     = in_valid & in_ready;
  assign dump_en  = (state_q == StDump);

  // Extra bit so a zero budget (compare against 0) still ends after one cycle.
  assign cyc_inc  = {1'b0, cyc_cnt_q} + (CYC_W + 1)'(1);
  assign run_last = (cyc_inc >= {1'b0, run_q}) | cpu_halt;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    run_d      = run_q;
    cyc_cnt_d  = cyc_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (prog_len == '0) begin
            err_d = 1'b1;
          end else begin
            len_d      = prog_len;
            run_d      = run_cycles;
            word_cnt_d = '0;
            state_d    = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          we_d       = 1'b1;
          waddr_d    = ADDR_W'(word_cnt_q) * ADDR_W'(IM_STRIDE);
          wdata_d    = in_instr;
          word_cnt_d = word_cnt_q + LEN_W'(1);
        end
        // Leave only once the final write strobe has been issued.
        if (we_q && (word_cnt_q == len_q)) begin
          state_d   = StRun;
          cyc_cnt_d = '0;
        end
      end
      StRun: begin
        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        if (run_last) begin
          state_d = StDump;
        end
      end
      StDump: begin
        if (dump_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      run_q      <= '0;
      cyc_cnt_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      run_q      <= run_d;
      cyc_cnt_q  <= cyc_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  prog_run_dump_port #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_port (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (dump_en),
    .dm_addr_o    (dm_addr),
    .dm_rdata_i   (dm_rdata),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_data_o  (dump_data),
    .dump_idx_o   (dump_idx),
    .last_o       (dump_last)
  );

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = (state_q != StRun);
  assign dm_sel     = dump_en;
  assign busy       = (state_q == StLoad) || (state_q == StRun) || (state_q == StDump);
  assign done       = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Self-checking bench for prog_run_ctrl: directed scenarios with randomized
// program words, DM contents, loader gaps, halt timing and consumer stalls.
module tb_prog_run_ctrl;

  localparam int ADDR_W     = 64;
  localparam int INSTR_W    = 32;
  localparam int DATA_W     = 64;
  localparam int LEN_W      = 10;
  localparam int CYC_W      = 16;
  localparam int DUMP_WORDS = 32;
  localparam int IDXW       = $clog2(DUMP_WORDS);
  localparam int NO_HALT    = 100000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   prog_len = '0;
  logic [CYC_W-1:0]   run_cycles = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_rst;
  logic               cpu_halt = 1'b0;
  logic               dm_sel;
  logic [ADDR_W-1:0]  dm_addr;
  logic [DATA_W-1:0]  dm_rdata;
  logic               dump_valid;
  logic               dump_ready = 1'b0;
  logic [DATA_W-1:0]  dump_data;
  logic [LEN_W-1:0]   dump_idx;
  logic               busy;
  logic               done;
  logic               err;

  logic [DATA_W-1:0]  dm_mem [DUMP_WORDS];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Behavioural data memory seen by the DUT's read port.
  assign dm_rdata = (dm_addr < 64'(DUMP_WORDS * 8)) ? dm_mem[dm_addr[IDXW+2:3]] : '0;

  prog_run_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .cpu_halt   (cpu_halt),
    .dm_sel     (dm_sel),
    .dm_addr    (dm_addr),
    .dm_rdata   (dm_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_idx   (dump_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " cpu_rst"},    64'(cpu_rst),    64'(1));
    chk({nm, " in_ready"},   64'(in_ready),   64'(0));
    chk({nm, " imem_we"},    64'(imem_we),    64'(0));
    chk({nm, " dm_sel"},     64'(dm_sel),     64'(0));
    chk({nm, " dump_valid"}, 64'(dump_valid), 64'(0));
    chk({nm, " busy"},       64'(busy),       64'(0));
    chk({nm, " done"},       64'(done),       64'(0));
    chk({nm, " err"},        64'(err),        64'(0));
    chk({nm, " imem_addr"},  imem_addr,       64'(0));
    chk({nm, " imem_wdata"}, 64'(imem_wdata), 64'(0));
    chk({nm, " dm_addr"},    dm_addr,         64'(0));
    chk({nm, " dump_data"},  dump_data,       64'(0));
    chk({nm, " dump_idx"},   64'(dump_idx),   64'(0));
  endtask

  // Start with a zero-length program: expect a one-cycle err pulse, no state change.
  task automatic reject_start(input string nm, input bit exp_done);
    @(negedge clk);
    start = 1'b1; prog_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " err pulse"}, 64'(err), 64'(1));
    chk({nm, " busy"},      64'(busy), 64'(0));
    @(negedge clk);
    chk({nm, " err cleared"}, 64'(err),  64'(0));
    chk({nm, " done kept"},   64'(done), 64'(exp_done));
    chk({nm, " in_ready"},    64'(in_ready), 64'(0));
  endtask

  // One full load/run/dump pass, checked against the rules directly:
  // write i goes to 4*i with word i; core runs min(max(rc,1), halt_at+1) cycles
  // starting right after the last write; beat i carries DM word i at 8*i.
  task automatic run_prog(input string nm, input int len, input int rc, input int halt_at,
                          input bit gappy, input int bp_beat, input int bp_len,
                          input bit rand_ready, input int abort_beat, output bit aborted);
    logic [INSTR_W-1:0] prog[$];
    logic [DATA_W-1:0]  held_data;
    logic [LEN_W-1:0]   held_idx;
    int ptr, nwr, nlow, beats, hold, cyc, last_we, first_low, exp_low;
    int err_bad, sel_bad, stable_bad, bubble_bad;
    bit prev_hs, holding, tog;

    ptr = 0; nwr = 0; nlow = 0; beats = 0; hold = 0; cyc = 0;
    last_we = -10; first_low = -1;
    err_bad = 0; sel_bad = 0; stable_bad = 0; bubble_bad = 0;
    prev_hs = 1'b0; holding = 1'b0; tog = 1'b0; aborted = 1'b0;
    held_data = '0; held_idx = '0;

    for (int i = 0; i < len; i++) prog.push_back($urandom);
    for (int i = 0; i < DUMP_WORDS; i++) dm_mem[IDXW'(i)] = {$urandom, $urandom};

    @(negedge clk);
    start = 1'b1; prog_len = LEN_W'(len); run_cycles = CYC_W'(rc);
    @(negedge clk);
    start = 1'b0; prog_len = '0;
    chk({nm, " busy after start"}, 64'(busy), 64'(1));
    chk({nm, " done cleared"},     64'(done), 64'(0));

    while (cyc < 3000) begin
      if (imem_we) begin
        if (nwr < len) begin
          chk($sformatf("%s write %0d addr", nm, nwr), imem_addr, 64'(4 * nwr));
          chk($sformatf("%s write %0d data", nm, nwr), 64'(imem_wdata), 64'(prog[nwr]));
        end
        nwr++;
        last_we = cyc;
      end
      if (!cpu_rst) begin
        if (first_low < 0) first_low = cyc;
        nlow++;
      end
      if (err) err_bad++;
      if (prev_hs && dump_valid) bubble_bad++;
      if (dump_valid) begin
        if (!dm_sel) sel_bad++;
        if (holding && (dump_data !== held_data || dump_idx !== held_idx)) stable_bad++;
        if (abort_beat >= 0 && beats == abort_beat) begin
          rst = 1'b1;
          aborted = 1'b1;
          break;
        end
      end
      if (done) break;

      tog      = ~tog;
      in_valid = (ptr < len) && (!gappy || tog);
      in_instr = in_valid ? prog[ptr] : '0;
      if (in_valid && in_ready) ptr++;
      // Random halt noise outside RUN must be ignored.
      if (first_low < 0 || cpu_rst) cpu_halt = ($urandom_range(0, 1) == 1);
      else cpu_halt = (nlow - 1 == halt_at);
      // Starts while busy must be ignored (a zero length would otherwise err).
      start = !cpu_rst && ($urandom_range(0, 1) == 1);

      prev_hs = 1'b0;
      if (dump_valid) begin
        if (beats == bp_beat && hold < bp_len) begin
          dump_ready = 1'b0;
          hold++;
        end else if (rand_ready) begin
          dump_ready = ($urandom_range(0, 3) != 0);
        end else begin
          dump_ready = 1'b1;
        end
        if (!dump_ready) begin
          holding   = 1'b1;
          held_data = dump_data;
          held_idx  = dump_idx;
        end else begin
          chk($sformatf("%s beat %0d data", nm, beats), dump_data, dm_mem[IDXW'(beats)]);
          chk($sformatf("%s beat %0d idx", nm, beats), 64'(dump_idx), 64'(beats));
          chk($sformatf("%s beat %0d dm_addr", nm, beats), dm_addr, 64'(8 * beats));
          beats++;
          prev_hs = 1'b1;
          holding = 1'b0;
        end
      end else begin
        dump_ready = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      cyc++;
    end

    in_valid = 1'b0; cpu_halt = 1'b0; start = 1'b0; dump_ready = 1'b0;

    exp_low = (rc == 0) ? 1 : rc;
    if (halt_at + 1 < exp_low) exp_low = halt_at + 1;

    chk({nm, " write count"},       64'(nwr),  64'(len));
    chk({nm, " run cycles"},        64'(nlow), 64'(exp_low));
    chk({nm, " run follows load"},  64'(first_low), 64'(last_we + 1));
    chk({nm, " no err while busy"}, 64'(err_bad), 64'(0));
    chk({nm, " dm_sel in dump"},    64'(sel_bad), 64'(0));
    chk({nm, " stall stability"},   64'(stable_bad), 64'(0));
    chk({nm, " bubble after beat"}, 64'(bubble_bad), 64'(0));
    if (abort_beat < 0) begin
      chk({nm, " reached done"}, 64'(done), 64'(1));
      chk({nm, " beat count"},   64'(beats), 64'(DUMP_WORDS));
      chk({nm, " busy at done"}, 64'(busy), 64'(0));
      chk({nm, " dm_sel at done"}, 64'(dm_sel), 64'(0));
      chk({nm, " cpu_rst at done"}, 64'(cpu_rst), 64'(1));
    end
  endtask

  initial begin
    bit ab;
    int quiet_bad;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    reject_start("idle zero len", 1'b0);

    run_prog("basic", 15, 20, NO_HALT, 1'b0, 2, 3, 1'b0, -1, ab);

    reject_start("done zero len", 1'b1);

    run_prog("gappy halt", 3, 100, 5, 1'b1, -1, 0, 1'b0, -1, ab);

    for (int r = 0; r < 3; r++) begin
      run_prog($sformatf("rand%0d", r), int'($urandom_range(1, 20)),
               (r == 0) ? 0 : int'($urandom_range(1, 30)), int'($urandom_range(0, 40)),
               ($urandom_range(0, 1) == 1), -1, 0, 1'b1, -1, ab);
    end

    run_prog("abort", 4, 6, NO_HALT, 1'b0, -1, 0, 1'b0, 10, ab);
    chk("abort reached beat 10", 64'(ab), 64'(1));
    @(negedge clk);
    check_reset("abort");
    rst = 1'b0;
    quiet_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (imem_we || dump_valid || busy || !cpu_rst) quiet_bad++;
    end
    chk("abort stays idle", 64'(quiet_bad), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Boot/run sequencer for the pipelined RISC-V core.
- Loads a program word stream into instruction memory at consecutive word addresses, then holds the core in reset until loading completes.
- Releases the core for a bounded cycle budget, or until it halts, then takes ownership of the data-memory read port and streams out DM contents.
- Sits between the bench/host loader and the core top; replaces ad-hoc in_enable/Addr driving.

Parameters:
- ADDR_W, 64, width of IM/DM byte addresses.
- INSTR_W, 32, instruction word width.
- DATA_W, 64, DM word width.
- LEN_W, 10, width of program length count.
- CYC_W, 16, width of run-cycle budget.
- DUMP_WORDS, 32, number of DM words streamed out after the run.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin load/run/dump.
- prog_len  in  LEN_W  instruction count; sampled when start is accepted.
- run_cycles  in  CYC_W  run budget; sampled when start is accepted.
- in_valid  in  1  loader word valid.
- in_ready  out  1  controller accepts a loader word.
- in_instr  in  INSTR_W  loader instruction word.
- imem_we  out  1  IM write strobe.
- imem_addr  out  ADDR_W  IM byte address.
- imem_wdata  out  INSTR_W  IM write data.
- cpu_rst  out  1  holds the core in reset (active-high).
- cpu_halt  in  1  core halt indication; honoured in RUN only.
- dm_sel  out  1  1 = controller owns the DM read port; 0 = core owns it.
- dm_addr  out  ADDR_W  DM byte address while dm_sel = 1.
- dm_rdata  in  DATA_W  DM combinational read data.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  dump consumer ready.
- dump_data  out  DATA_W  dump word.
- dump_idx  out  LEN_W  index of the current dump word.
- busy  out  1  high in LOAD, RUN and DUMP.
- done  out  1  high in DONE until the next accepted start.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset values:
  - State = IDLE; cpu_rst = 1.
  - in_ready, imem_we, dm_sel, dump_valid, busy, done, err = 0.
  - All addresses, data and counters = 0.
- Reset mid-operation aborts any transfer immediately. No further IM writes or dump beats occur.
- IDLE:
  - cpu_rst = 1.
  - start with prog_len == 0 gives an err pulse next cycle; state stays IDLE.
  - Otherwise, latch prog_len and run_cycles, clear done, and go to LOAD.
- LOAD:
  - in_ready = 1 while word_cnt < len.
  - Transfer occurs when in_valid && in_ready.
  - On the cycle after a transfer, imem_we = 1 for one cycle, imem_addr = word_cnt*4 (the pre-increment count), imem_wdata = the captured word.
  - word_cnt then increments.
  - After the last word is accepted, in_ready drops in the following cycle.
  - The state moves to RUN on the cycle after the final imem_we.
- RUN:
  - cpu_rst = 0; cyc_cnt counts from 0.
  - Leave RUN when cyc_cnt == run_cycles-1, or when cpu_halt is sampled high, whichever comes first.
  - run_cycles == 0 is treated as a 1-cycle run.
  - On exit: cpu_rst = 1 the next cycle and the state goes to DUMP. cpu_halt is ignored outside RUN.
- DUMP:
  - dm_sel = 1; dm_addr = dump_idx*8.
  - dm_rdata is registered into dump_data with dump_valid = 1 one cycle after the address is presented.
  - dump_data and dump_idx hold stable while dump_valid && !dump_ready.
  - On handshake, dump_idx increments and the next beat follows with one bubble cycle.
  - After beat DUMP_WORDS-1 is accepted: dm_sel = 0, state goes to DONE.
- DONE:
  - done = 1; cpu_rst = 1.
  - An accepted start behaves as in IDLE.
- start is ignored while busy = 1. No err is raised for it.
- Address arithmetic is modulo 2^ADDR_W. No wrap is reachable under the default parameters.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, RUN, DUMP, DONE);
  - the word-stride constants IM_STRIDE = 4 and DM_STRIDE = 8.
- One natural sub-module: prog_run_dump_port, a DM read-address generator plus a valid/ready output register.

Test Plan:
- Basic load: reset, then start with prog_len = 15 and 15 back-to-back words → 15 imem_we pulses at addresses 0, 4, …, 56 with data matching the input; cpu_rst stays 1 throughout LOAD.
- Gappy input: in_valid toggles every other cycle, prog_len = 3 → exactly 3 writes at addresses 0, 4, 8; no duplicate writes.
- Run budget: run_cycles = 20, cpu_halt = 0 → cpu_rst low for exactly 20 cycles; DUMP entered; dm_sel = 1.
- Halt preempts budget: cpu_halt raised on RUN cycle 5 with run_cycles = 100 → cpu_rst returns to 1 on the next cycle.
- Dump backpressure: dump_ready low for 3 cycles on beat 2 → dump_data and dump_idx = 2 held stable; 32 beats total with addresses 0 to 248; then done = 1.
- Error and abort:
  - prog_len = 0 → err pulse and state stays IDLE.
  - rst asserted during beat 10 of DUMP → all outputs return to reset values on the next edge.
